string_printer: RTL

// Responder side of the printer_enable / printer_str_id / printer_done handshake driven by the

---
 rtl/string_printer_pkg.sv | 54 +++++
 rtl/string_printer_str_rom.sv | 34 +++
 rtl/string_printer.sv | 107 ++++++++++
 3 files changed

// File: rtl/string_printer_pkg.sv
// Shared definitions for the string printer: FSM encodings, string IDs and the built-in string image.
`default_nettype none

package string_printer_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_CHECK = 3'd2;
  localparam logic [2:0] ST_SEND  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // The calling command FSMs select strings with these same IDs.
  localparam int unsigned STR_WELCOME = 0;
  localparam int unsigned STR_PROMPT  = 1;
  localparam int unsigned STR_OK      = 2;
  localparam int unsigned STR_ERROR   = 3;

  localparam logic [7:0] NUL_CHAR = 8'h00;

  // Byte at offset of string slot; anything not listed reads as the terminator.
  function automatic logic [7:0] image_byte(input int unsigned slot, input int unsigned offset);
    logic [7:0] b;
    b = NUL_CHAR;
    case (slot)
      STR_WELCOME: begin
        case (offset)
          0: b = 8'h48;
          1: b = 8'h69;
          2: b = 8'h0D;
          3: b = 8'h0A;
          default: b = NUL_CHAR;
        endcase
      end
      // Prompt slot is a full-length unterminated line of printable characters.
      STR_PROMPT: b = (offset < 32'd64) ? 8'(32'h21 + offset) : NUL_CHAR;
      STR_OK:     b = NUL_CHAR;
      STR_ERROR: begin
        case (offset)
          0: b = 8'h45;
          1: b = 8'h52;
          2: b = 8'h52;
          3: b = 8'h0D;
          4: b = 8'h0A;
          default: b = NUL_CHAR;
        endcase
      end
      default: b = NUL_CHAR;
    endcase
    return b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/string_printer_str_rom.sv
// String ROM with a one-cycle registered read; addresses outside the image read as NUL.
`default_nettype none

module str_rom
  import string_printer_pkg::*;
#(
  parameter int unsigned DEPTH    = 128,
  parameter int unsigned SLOT_LEN = 32,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [7:0]        data
);

  logic [7:0] byte_d;
  logic [7:0] data_q;

  always_comb begin
    byte_d = NUL_CHAR;
    if (32'(addr) < DEPTH) begin
      byte_d = image_byte(32'(addr) / SLOT_LEN, 32'(addr) % SLOT_LEN);
    end
  end

  always_ff @(posedge clk) begin
    data_q <= byte_d;
  end

  assign data = data_q;

endmodule

`default_nettype wire

// File: rtl/string_printer.sv
// Streams a NUL-terminated ROM string to the UART transmitter on request, then pulses done.
`default_nettype none

module string_printer
  import string_printer_pkg::*;
#(
  parameter int unsigned NUM_STRS = 4,
  parameter int unsigned STR_ID_W = 2,
  parameter int unsigned MAX_LEN  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                printer_enable,
  input  logic [STR_ID_W-1:0] printer_str_id,
  output logic                printer_done,
  output logic                printer_busy,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready
);

  // One extra index bit so a full MAX_LEN-byte string can be counted without wrapping.
  localparam int unsigned IDX_W  = $clog2(MAX_LEN) + 1;
  localparam int unsigned ADDR_W = STR_ID_W + $clog2(MAX_LEN);

  logic [2:0]          state_q, state_d;
  logic [STR_ID_W-1:0] id_q, id_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [7:0]          tx_data_q, tx_data_d;
  logic                tx_valid_q, tx_valid_d;
  logic                done_q, busy_q;
  logic [7:0]          rom_data;

  str_rom #(
    .DEPTH    (NUM_STRS * MAX_LEN),
    .SLOT_LEN (MAX_LEN),
    .ADDR_W   (ADDR_W)
  ) u_rom (
    .clk  (clk),
    .addr ({id_q, index_q[IDX_W-2:0]}),
    .data (rom_data)
  );

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    index_d    = index_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (printer_enable) begin
          id_d    = printer_str_id;
          index_d = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_CHECK;
      ST_CHECK: begin
        if (rom_data == NUL_CHAR || index_q == IDX_W'(MAX_LEN)) begin
          state_d = ST_DONE;
        end else begin
          tx_data_d  = rom_data;
          tx_valid_d = 1'b1;
          state_d    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          index_d    = index_q + 1'b1;
          state_d    = ST_FETCH;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      id_q       <= '0;
      index_q    <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      index_q    <= index_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      done_q     <= (state_d == ST_DONE);
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign printer_done = done_q;
  assign printer_busy = busy_q;
  assign tx_data      = tx_data_q;
  assign tx_valid     = tx_valid_q;

endmodule

`default_nettype wire
